// File: rtl/reg_bank_pkg.sv
// Shared definitions for the parametrised register bank.
// Holds the write-source encodings and the sequencer state type.
package reg_bank_pkg;

  localparam logic [2:0] SEL_INA   = 3'd0;
  localparam logic [2:0] SEL_INB   = 3'd1;
  localparam logic [2:0] SEL_CONST = 3'd2;
  localparam logic [2:0] SEL_ALU   = 3'd3;
  localparam logic [2:0] SEL_REG   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DUMP
  } seq_state_e;

endpackage

// File: rtl/reg_bank_param_if.sv
// Bus bundle between the control unit / debug path (master) and the register bank (slave).
interface reg_bank_param_if #(
  parameter int DW   = 8,
  parameter int NREG = 16
);
  localparam int AW = $clog2(NREG);

  logic [2:0]    in_sel;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] cu_const;
  logic [DW-1:0] alu_out;
  logic [AW-1:0] src_addr;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic [DW-1:0] out_q;
  logic [DW-1:0] out_r;
  logic          clr_req;
  logic          dump_req;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          busy;

  modport master (
    output in_sel, in_a, in_b, cu_const, alu_out, src_addr, we, wr_addr,
           rd_addr_a, rd_addr_b, clr_req, dump_req, dump_ready,
    input  rd_data_a, rd_data_b, out_q, out_r, dump_valid, dump_addr,
           dump_data, busy
  );

  modport slave (
    input  in_sel, in_a, in_b, cu_const, alu_out, src_addr, we, wr_addr,
           rd_addr_a, rd_addr_b, clr_req, dump_req, dump_ready,
    output rd_data_a, rd_data_b, out_q, out_r, dump_valid, dump_addr,
           dump_data, busy
  );

endinterface

// File: rtl/reg_bank_seq.sv
// Bulk-clear / register-dump sequencer for the register bank.
// Walks a counter over every register index and exits at the last one.
module reg_bank_seq
  import reg_bank_pkg::*;
#(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  input  logic          dump_req,
  input  logic          dump_ready,
  output logic          busy,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // clear has priority; a coincident dump request is dropped
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (dump_req) begin
          state_d = ST_DUMP;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_DUMP: begin
        if (dump_ready) begin
          if (cnt_q == LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign clear_we   = (state_q == ST_CLEAR);
  assign clear_addr = cnt_q;
  assign dump_valid = (state_q == ST_DUMP);
  assign dump_addr  = dump_valid ? cnt_q : '0;

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank: write-source mux, two read ports with optional
// write-through bypass, fixed Q/R taps, and a clear/dump sequencer.
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int DW     = 8,
  parameter int NREG   = 16,
  parameter int Q_IDX  = 0,
  parameter int R_IDX  = 14,
  parameter bit BYPASS = 1'b1
) (
  input logic             clk,
  input logic             rst,
  reg_bank_param_if.slave bus
);

  localparam int AW    = $clog2(NREG);
  localparam int NVIEW = 2 ** AW;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] view   [NVIEW];
  logic [DW-1:0] wdata;
  logic          wr_en;
  logic          busy;
  logic          clear_we;
  logic [AW-1:0] clear_addr;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;

  reg_bank_seq #(.NREG(NREG), .AW(AW)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (bus.clr_req),
    .dump_req   (bus.dump_req),
    .dump_ready (bus.dump_ready),
    .busy       (busy),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr)
  );

  // Addresses beyond NREG read as zero when the depth is not a power of two
  for (genvar i = 0; i < NVIEW; i++) begin : g_view
    if (i < NREG) begin : g_real
      assign view[i] = regs_q[i];
    end else begin : g_pad
      assign view[i] = '0;
    end
  end

  always_comb begin
    case (bus.in_sel)
      SEL_INA:   wdata = bus.in_a;
      SEL_INB:   wdata = bus.in_b;
      SEL_CONST: wdata = bus.cu_const;
      SEL_ALU:   wdata = bus.alu_out;
      default:   wdata = view[bus.src_addr];
    endcase
  end

  assign wr_en = bus.we && !busy && (int'(bus.wr_addr) < NREG);

  always_comb begin
    regs_d = regs_q;
    if (clear_we) begin
      if (int'(clear_addr) < NREG) regs_d[clear_addr] = '0;
    end else if (wr_en) begin
      regs_d[bus.wr_addr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.rd_data_a = (BYPASS && wr_en && (bus.wr_addr == bus.rd_addr_a)) ?
                         wdata : view[bus.rd_addr_a];
  assign bus.rd_data_b = (BYPASS && wr_en && (bus.wr_addr == bus.rd_addr_b)) ?
                         wdata : view[bus.rd_addr_b];

  assign bus.out_q      = regs_q[Q_IDX];
  assign bus.out_r      = regs_q[R_IDX];
  assign bus.busy       = busy;
  assign bus.dump_valid = dump_valid;
  assign bus.dump_addr  = dump_addr;
  assign bus.dump_data  = dump_valid ? view[dump_addr] : '0;

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed self-checking bench for reg_bank_param; a second instance with
// BYPASS=0 shadows the main one on the same stimulus.
module tb_reg_bank_param;
  import reg_bank_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  reg_bank_param_if #(.DW(8), .NREG(16)) bus  ();
  reg_bank_param_if #(.DW(8), .NREG(16)) bus0 ();

  reg_bank_param #(.DW(8), .NREG(16), .Q_IDX(0), .R_IDX(14), .BYPASS(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  reg_bank_param #(.DW(8), .NREG(16), .Q_IDX(0), .R_IDX(14), .BYPASS(1'b0)) dut_nobyp (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  // The no-bypass instance sees exactly the same inputs as the main one
  assign bus0.in_sel     = bus.in_sel;
  assign bus0.in_a       = bus.in_a;
  assign bus0.in_b       = bus.in_b;
  assign bus0.cu_const   = bus.cu_const;
  assign bus0.alu_out    = bus.alu_out;
  assign bus0.src_addr   = bus.src_addr;
  assign bus0.we         = bus.we;
  assign bus0.wr_addr    = bus.wr_addr;
  assign bus0.rd_addr_a  = bus.rd_addr_a;
  assign bus0.rd_addr_b  = bus.rd_addr_b;
  assign bus0.clr_req    = bus.clr_req;
  assign bus0.dump_req   = bus.dump_req;
  assign bus0.dump_ready = bus.dump_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so inputs and samples sit away from it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // One counted comparison; failures are reported and counted, never fatal
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-cycle write through source in_a
  task automatic writeReg(input logic [3:0] addr, input logic [7:0] val);
    bus.in_sel  = SEL_INA;
    bus.in_a    = val;
    bus.wr_addr = addr;
    bus.we      = 1'b1;
    applyStimulus();
    bus.we      = 1'b0;
  endtask

  // Read a register through port A with no write in flight
  task automatic readA(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    bus.rd_addr_a = addr;
    #1;
    checkOutput(tag, 32'(bus.rd_data_a), 32'(exp));
  endtask

  initial begin
    int n;
    int seen_valid;
    int nonzero;
    int exp_idx;
    int cycles;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_sel = '0; bus.in_a = '0; bus.in_b = '0; bus.cu_const = '0;
    bus.alu_out = '0; bus.src_addr = '0; bus.we = 1'b0; bus.wr_addr = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.clr_req = 1'b0;
    bus.dump_req = 1'b0; bus.dump_ready = 1'b0;

    // Reset state
    applyStimulus();
    applyStimulus();
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_dump_valid", 32'(bus.dump_valid), 32'h0);
    checkOutput("rst_dump_addr", 32'(bus.dump_addr), 32'h0);
    checkOutput("rst_dump_data", 32'(bus.dump_data), 32'h0);
    checkOutput("rst_out_q", 32'(bus.out_q), 32'h0);
    checkOutput("rst_out_r", 32'(bus.out_r), 32'h0);
    rst = 1'b0;

    // Plain write from in_a, bypassed on port A in the same cycle
    bus.in_sel = SEL_INA; bus.in_a = 8'h5A; bus.wr_addr = 4'd3; bus.we = 1'b1;
    bus.rd_addr_a = 4'd3;
    #1;
    checkOutput("wr_bypass_a", 32'(bus.rd_data_a), 32'h5A);
    applyStimulus();
    bus.we = 1'b0;
    readA("wr_reg3", 4'd3, 8'h5A);
    readA("wr_reg2_untouched", 4'd2, 8'h00);
    readA("wr_reg4_untouched", 4'd4, 8'h00);

    // ALU write with bypass on port B; no-bypass instance shows old value first
    bus.in_sel = SEL_ALU; bus.alu_out = 8'h7E; bus.wr_addr = 4'd2; bus.we = 1'b1;
    bus.rd_addr_b = 4'd2;
    #1;
    checkOutput("byp_b_same_cycle", 32'(bus.rd_data_b), 32'h7E);
    checkOutput("nobyp_b_same_cycle", 32'(bus0.rd_data_b), 32'h00);
    applyStimulus();
    bus.we = 1'b0;
    #1;
    checkOutput("nobyp_b_next_cycle", 32'(bus0.rd_data_b), 32'h7E);

    // Register move into the R tap, then a constant into the Q tap
    bus.in_sel = SEL_INB; bus.in_b = 8'h11; bus.wr_addr = 4'd5; bus.we = 1'b1;
    applyStimulus();
    bus.in_sel = SEL_REG; bus.src_addr = 4'd5; bus.wr_addr = 4'd14;
    #1;
    checkOutput("out_r_not_bypassed", 32'(bus.out_r), 32'h00);
    applyStimulus();
    bus.we = 1'b0;
    checkOutput("move_out_r", 32'(bus.out_r), 32'h11);
    bus.in_sel = SEL_CONST; bus.cu_const = 8'h22; bus.wr_addr = 4'd0; bus.we = 1'b1;
    applyStimulus();
    bus.we = 1'b0;
    checkOutput("const_out_q", 32'(bus.out_q), 32'h22);
    // Move with source equal to destination keeps the value
    bus.in_sel = SEL_REG; bus.src_addr = 4'd5; bus.wr_addr = 4'd5; bus.we = 1'b1;
    applyStimulus();
    bus.we = 1'b0;
    readA("self_move_reg5", 4'd5, 8'h11);

    // Bulk clear with a write attempt in the middle
    for (int i = 0; i < 16; i++) writeReg(4'(i), 8'(8'hA0 + i));
    bus.clr_req = 1'b1;
    n = 0;
    seen_valid = 0;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus();
      bus.clr_req = 1'b0;
      bus.in_sel = SEL_INA; bus.in_a = 8'hFF; bus.wr_addr = 4'd3;
      bus.we = (i == 12);
      if (bus.dump_valid) seen_valid++;
      if (!bus.busy) break;
      n++;
    end
    bus.we = 1'b0;
    checkOutput("clear_busy_cycles", 32'(n), 32'd16);
    checkOutput("clear_no_dump_valid", 32'(seen_valid), 32'd0);
    nonzero = 0;
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr_a = 4'(i);
      #1;
      if (bus.rd_data_a !== 8'h00) nonzero++;
    end
    checkOutput("clear_all_zero", 32'(nonzero), 32'd0);
    readA("clear_we_ignored_reg3", 4'd3, 8'h00);

    // Dump with ready toggling every other cycle
    for (int i = 0; i < 16; i++) writeReg(4'(i), 8'(i + 1));
    bus.dump_req = 1'b1;
    applyStimulus();
    bus.dump_req = 1'b0;
    exp_idx = 0;
    cycles = 0;
    while (exp_idx < 16 && cycles < 100) begin
      checkOutput("dump_valid", 32'(bus.dump_valid), 32'h1);
      checkOutput("dump_addr", 32'(bus.dump_addr), 32'(exp_idx));
      checkOutput("dump_data", 32'(bus.dump_data), 32'(exp_idx + 1));
      bus.dump_ready = cycles[0];
      if (bus.dump_ready) exp_idx++;
      applyStimulus();
      cycles++;
    end
    bus.dump_ready = 1'b0;
    checkOutput("dump_word_count", 32'(exp_idx), 32'd16);
    checkOutput("dump_end_valid", 32'(bus.dump_valid), 32'h0);
    checkOutput("dump_end_busy", 32'(bus.busy), 32'h0);
    checkOutput("dump_end_addr", 32'(bus.dump_addr), 32'h0);

    // Simultaneous clear and dump requests: clear only
    bus.clr_req = 1'b1;
    bus.dump_req = 1'b1;
    n = 0;
    seen_valid = 0;
    for (int i = 1; i <= 60; i++) begin
      applyStimulus();
      bus.clr_req = 1'b0;
      bus.dump_req = 1'b0;
      if (bus.dump_valid) seen_valid++;
      if (!bus.busy) break;
      n++;
    end
    checkOutput("both_req_busy_cycles", 32'(n), 32'd16);
    checkOutput("both_req_no_dump", 32'(seen_valid), 32'd0);
    readA("both_req_reg9_cleared", 4'd9, 8'h00);

    // Reset during a dump at word 7 aborts everything
    for (int i = 0; i < 16; i++) writeReg(4'(i), 8'(i + 1));
    bus.dump_req = 1'b1;
    bus.dump_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      bus.dump_req = 1'b0;
      if (bus.dump_addr == 4'd7) break;
    end
    checkOutput("mid_dump_addr", 32'(bus.dump_addr), 32'd7);
    checkOutput("mid_dump_data", 32'(bus.dump_data), 32'h08);
    rst = 1'b1;
    #1;
    checkOutput("abort_dump_valid", 32'(bus.dump_valid), 32'h0);
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    checkOutput("abort_out_q", 32'(bus.out_q), 32'h0);
    readA("abort_reg7_zero", 4'd7, 8'h00);
    readA("abort_reg15_zero", 4'd15, 8'h00);
    #2;
    rst = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("no_resume_busy", 32'(bus.busy), 32'h0);
    checkOutput("no_resume_valid", 32'(bus.dump_valid), 32'h0);
    bus.dump_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
- Parametrised register bank for the datapath; successor of the fixed 16x8 bank.
- Configurable word width and depth; write-source mux; two addressable ALU read ports with optional write-through bypass.
- Fixed Q/R result taps.
- Internal sequencer for a bulk-clear operation and a handshaked register dump, used by the control unit and the result/debug path.

Parameters:
- DW, 8, data width of every register and data port.
- NREG, 16, number of registers; must be ≥ 2.
- AW, $clog2(NREG), address width; derived, not overridden.
- Q_IDX, 0, register index driven on out_q.
- R_IDX, 14, register index driven on out_r.
- BYPASS, 1, 1 means read ports return the write data when reading the address being written in the same cycle.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_sel  in  3  write-source select: 0 in_a, 1 in_b, 2 cu_const, 3 alu_out, 4-7 register src_addr.
- in_a  in  DW  external operand A.
- in_b  in  DW  external operand B.
- cu_const  in  DW  control-unit constant.
- alu_out  in  DW  ALU result.
- src_addr  in  AW  source register for register-to-register moves.
- we  in  1  write enable.
- wr_addr  in  AW  destination register.
- rd_addr_a  in  AW  read port A address.
- rd_addr_b  in  AW  read port B address.
- rd_data_a  out  DW  read port A data (combinational).
- rd_data_b  out  DW  read port B data (combinational).
- out_q  out  DW  contents of reg[Q_IDX].
- out_r  out  DW  contents of reg[R_IDX].
- clr_req  in  1  single-cycle request: zero all registers.
- dump_req  in  1  single-cycle request: stream all registers out.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the dump word.
- dump_addr  out  AW  index of the current dump word.
- dump_data  out  DW  value of reg[dump_addr].
- busy  out  1  sequencer not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - All registers go to 0.
  - FSM goes to IDLE; counter goes to 0.
  - Outputs: busy=0, dump_valid=0, dump_addr=0, dump_data=0, out_q=0, out_r=0.
  - If reset arrives mid-CLEAR or mid-DUMP, the operation is aborted; there is no resume.
- Write path (IDLE only):
  - On the rising edge with we=1: reg[wr_addr] <= wdata, where wdata = mux(in_sel).
  - we=0 leaves every register unchanged. No latch: the enable decode is fully specified.
  - in_sel 4-7 reads reg[src_addr] before the edge. wr_addr == src_addr is legal and a no-op in value.
  - If NREG is not a power of 2, a write to an address ≥ NREG is dropped, and a read of an address ≥ NREG returns 0.
- Read path:
  - rd_data_x = reg[rd_addr_x], combinational, zero latency.
  - BYPASS=1 and we=1 and wr_addr == rd_addr_x in IDLE: rd_data_x = wdata.
  - BYPASS=0: the new value appears the cycle after the write edge.
- out_q and out_r are always the registered contents, never bypassed.
- FSM states: IDLE, CLEAR, DUMP.
- IDLE:
  - clr_req=1 → CLEAR, counter 0.
  - Otherwise dump_req=1 → DUMP, counter 0.
  - clr_req and dump_req in the same cycle: CLEAR wins and dump_req is dropped.
- CLEAR:
  - Each cycle reg[counter] <= 0, counter +1.
  - After counter = NREG-1 is written → IDLE.
  - Duration is exactly NREG cycles with busy=1.
- DUMP:
  - dump_valid=1, dump_addr=counter, dump_data=reg[counter].
  - On dump_valid and dump_ready: counter +1.
  - On the acceptance at counter = NREG-1 → IDLE, dump_valid=0 the next cycle.
  - dump_ready=0 holds the word stable (addr and data unchanged).
- While busy:
  - External we is ignored, which keeps dump contents consistent.
  - clr_req and dump_req are ignored; rd_data ports remain live.
- Counter is AW bits wide. It never wraps past NREG-1 because the FSM exits at the last index.
- dump_valid=0 in IDLE and CLEAR; dump_addr and dump_data are 0 outside DUMP.

Decomposition:
- Shared package reg_bank_pkg:
  - in_sel encodings as localparams: SEL_INA=0, SEL_INB=1, SEL_CONST=2, SEL_ALU=3, SEL_REG=4.
  - FSM state enum: ST_IDLE, ST_CLEAR, ST_DUMP.
- One natural sub-module: reg_bank_seq, containing the FSM, counter and handshake. It outputs clear_we, clear_addr, dump signals and busy.
- The top holds the register array, the write/read muxes and the bypass logic.

Test Plan:
- Reset then write in_sel=0, in_a=0x5A, we=1, wr_addr=3 → next cycle reg3 = 0x5A; rd_addr_a=3 gives 0x5A; other registers stay 0.
- Bypass: we=1, in_sel=3, alu_out=0x7E, wr_addr=rd_addr_b=2 → rd_data_b=0x7E in the same cycle. With BYPASS=0, the old value shows until the next cycle.
- Move and taps: reg5=0x11; in_sel=4, src_addr=5, wr_addr=14 → out_r=0x11; writing 0x22 to reg0 → out_q=0x22.
- Clear: fill all registers with nonzero values, pulse clr_req → busy=1 for exactly 16 cycles, all registers 0 afterwards; a we pulse during clear has no effect.
- Dump with back-pressure: registers = index+1, pulse dump_req, toggle dump_ready every other cycle → 16 words 0x01..0x10 in order, each held while ready=0, then busy=0.
- Simultaneous clr_req+dump_req → clear only, no dump_valid. Assert rst mid-dump at word 7 → dump_valid=0 and all registers 0 immediately; the FSM is in IDLE.
